// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, qualifies each digit for stability,
// decodes it to hex and presents a complete frame of NUM_DIGITS nibbles on valid/ready.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_digits,
    output logic [NUM_DIGITS-1:0]   out_invalid,
    output logic                    out_overrun
);

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

    logic [6:0]              prev_seg_q;
    logic [NUM_DIGITS-1:0]   prev_an_q;
    logic [7:0]              stable_cnt_q, stable_cnt_d;
    logic [NUM_DIGITS-1:0]   captured_q, captured_d;
    logic [4*NUM_DIGITS-1:0] slot_q, slot_d;
    logic [NUM_DIGITS-1:0]   inv_q, inv_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
    logic                    overrun_q, overrun_d;

    logic                    same;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    one_hot;
    logic                    capture;
    logic                    frame_done;
    logic                    xfer;
    logic [4:0]              dec;

    // Returns {illegal, nibble}; unknown glyphs decode to nibble 0 with the flag set.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        same    = ({an_in, seg_in} == {prev_an_q, prev_seg_q});
        sel     = ~an_in;
        one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        dec     = decode(seg_in);

        if (!same) begin
            stable_cnt_d = 8'd1;
        end else if (stable_cnt_q == StableMax) begin
            stable_cnt_d = stable_cnt_q;
        end else begin
            stable_cnt_d = stable_cnt_q + 8'd1;
        end

        // Only the transition into saturation captures, so a long hold fires once.
        capture = same && (stable_cnt_q == StableMax - 8'd1) && one_hot;
    end

    always_comb begin
        slot_d     = slot_q;
        inv_d      = inv_q;
        captured_d = captured_q;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    slot_d[4*i +: 4] = dec[3:0];
                    inv_d[i]         = dec[4];
                    captured_d[i]    = 1'b1;
                end
            end
        end
        frame_done = capture && (&captured_d);
        if (frame_done) begin
            captured_d = '0;
        end
    end

    always_comb begin
        xfer      = valid_q && out_ready;
        valid_d   = valid_q;
        digits_d  = digits_q;
        invalid_d = invalid_q;
        overrun_d = 1'b0;
        if (frame_done) begin
            if (!valid_q || xfer) begin
                valid_d   = 1'b1;
                digits_d  = slot_d;
                invalid_d = inv_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg_q   <= 7'h7F;
            prev_an_q    <= '1;
            stable_cnt_q <= 8'd0;
            captured_q   <= '0;
            slot_q       <= '0;
            inv_q        <= '0;
            valid_q      <= 1'b0;
            digits_q     <= '0;
            invalid_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            prev_seg_q   <= seg_in;
            prev_an_q    <= an_in;
            stable_cnt_q <= stable_cnt_d;
            captured_q   <= captured_d;
            slot_q       <= slot_d;
            inv_q        <= inv_d;
            valid_q      <= valid_d;
            digits_q     <= digits_d;
            invalid_q    <= invalid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_digits  = digits_q;
    assign out_invalid = invalid_q;
    assign out_overrun = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized scan traffic
// compared against a frame-level reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic          out_ready;
    logic          out_valid;
    logic [15:0]   out_digits;
    logic [ND-1:0] out_invalid;
    logic          out_overrun;

    int checks = 0;
    int errors = 0;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_digits (out_digits),
        .out_invalid(out_invalid),
        .out_overrun(out_overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: run length of identical samples, per-digit slots, output holding reg.
    int          m_run;
    logic [3:0]  m_prev_an;
    logic [6:0]  m_prev_seg;
    bit          m_cap [ND];
    int          m_slot [ND];
    bit          m_inv [ND];
    logic        m_valid;
    logic [15:0] m_digits;
    logic [3:0]  m_invalid;
    logic        m_overrun;

    task automatic model_reset();
        m_run = 0; m_prev_an = 4'hF; m_prev_seg = 7'h7F;
        for (int i = 0; i < ND; i++) begin m_cap[i] = 0; m_slot[i] = 0; m_inv[i] = 0; end
        m_valid = 0; m_digits = 0; m_invalid = 0; m_overrun = 0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic r);
        int  zeros, idx, val;
        bit  bad, all, frame, xfer;
        m_run = (a == m_prev_an && s == m_prev_seg) ? m_run + 1 : 1;
        m_prev_an = a; m_prev_seg = s;
        zeros = 0; idx = 0; frame = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) begin zeros++; idx = i; end
        if (m_run == ST && zeros == 1) begin
            val = 0; bad = 1;
            for (int g = 0; g < 16; g++) if (glyphs[g] == s) begin val = g; bad = 0; end
            m_slot[idx] = val; m_inv[idx] = bad; m_cap[idx] = 1;
            all = 1;
            for (int i = 0; i < ND; i++) all &= m_cap[i];
            if (all) begin
                frame = 1;
                for (int i = 0; i < ND; i++) m_cap[i] = 0;
            end
        end
        xfer = m_valid && r;
        m_overrun = 0;
        if (frame) begin
            if (!m_valid || xfer) begin
                m_valid = 1;
                for (int i = 0; i < ND; i++) begin
                    m_digits[4*i +: 4] = m_slot[i][3:0];
                    m_invalid[i] = m_inv[i];
                end
            end else begin
                m_overrun = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic r);
        an_in = a; seg_in = s; out_ready = r;
        @(posedge clk);
        model_edge(a, s, r);
        #1;
    endtask

    task automatic hold(input int d, input logic [6:0] g, input int n, input logic r);
        for (int k = 0; k < n; k++) step(~(4'b1 << d), g, r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; an_in = 4'hF; seg_in = 7'h7F; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_digits, out_invalid, out_overrun} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {out_valid, out_digits, out_invalid, out_overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(4'hF, 7'h7F, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [6:0] g [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
        for (int d = 0; d < 3; d++) hold(d, g[d], 6, 1'b1);
        hold(3, g[3], 3, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        hold(3, g[3], 1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'h4321 || out_invalid !== 4'h0) begin
            errors++;
            $display("FAIL basic_frame: got v=%b d=%h i=%b want v=1 d=4321 i=0000",
                     out_valid, out_digits, out_invalid);
        end
        hold(3, g[3], 1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_digits !== 16'h4321) begin
            errors++;
            $display("FAIL basic_xfer: got v=%b d=%h want v=0 d=4321", out_valid, out_digits);
        end
    endtask

    task automatic test_glitch();
        hold(0, 7'h40, 3, 1'b1);
        hold(0, 7'h79, 5, 1'b1);
        hold(1, 7'h24, 5, 1'b1);
        hold(2, 7'h30, 5, 1'b1);
        hold(3, 7'h19, 4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'h4321) begin
            errors++;
            $display("FAIL glitch_frame: got v=%b d=%h want v=1 d=4321", out_valid, out_digits);
        end
        hold(3, 7'h19, 1, 1'b1);
    endtask

    task automatic test_illegal();
        hold(0, 7'h40, 4, 1'b1);
        hold(1, 7'h79, 4, 1'b1);
        hold(2, 7'h7F, 4, 1'b1);
        hold(3, 7'h24, 4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'h2010 || out_invalid !== 4'b0100) begin
            errors++;
            $display("FAIL illegal_frame: got v=%b d=%h i=%b want v=1 d=2010 i=0100",
                     out_valid, out_digits, out_invalid);
        end
        hold(3, 7'h24, 1, 1'b1);
    endtask

    task automatic test_two_hot();
        hold(0, 7'h12, 4, 1'b1);
        hold(1, 7'h02, 4, 1'b1);
        hold(2, 7'h78, 4, 1'b1);
        for (int k = 0; k < 10; k++) step(4'b0011, 7'h40, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_hot_capture: got v=%b want 0", out_valid);
        end
        hold(3, 7'h00, 4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'h8765) begin
            errors++;
            $display("FAIL two_hot_frame: got v=%b d=%h want v=1 d=8765", out_valid, out_digits);
        end
        hold(3, 7'h00, 1, 1'b1);
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        for (int d = 0; d < 4; d++) hold(d, 7'h79, 4, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'h1111) begin
            errors++;
            $display("FAIL bp_first: got v=%b d=%h want v=1 d=1111", out_valid, out_digits);
        end
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                step(~(4'b1 << d), 7'h24, 1'b0);
                if (out_overrun === 1'b1) pulses++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(4'b1110, 7'h24, 1'b0);
            if (out_overrun === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || out_digits !== 16'h1111 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun: got pulses=%0d d=%h v=%b want 1 1111 1",
                     pulses, out_digits, out_valid);
        end
        for (int d = 0; d < 3; d++) hold(d, 7'h30, 4, 1'b0);
        hold(3, 7'h30, 3, 1'b0);
        hold(3, 7'h30, 1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'h3333 || out_overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_third: got v=%b d=%h o=%b want v=1 d=3333 o=0",
                     out_valid, out_digits, out_overrun);
        end
        hold(3, 7'h30, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        hold(0, 7'h21, 4, 1'b0);
        hold(1, 7'h06, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_digits, out_invalid, out_overrun} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h want 0",
                     {out_valid, out_digits, out_invalid, out_overrun});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(2, 7'h0E, 4, 1'b1);
        hold(3, 7'h46, 4, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_partial: got v=%b want 0", out_valid);
        end
        hold(0, 7'h08, 4, 1'b1);
        hold(1, 7'h03, 4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_digits !== 16'hCFBA) begin
            errors++;
            $display("FAIL mid_reset_frame: got v=%b d=%h want v=1 d=cfba", out_valid, out_digits);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int         n;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(9) < 8) a = ~(4'b1 << $urandom_range(3));
            else a = 4'($urandom);
            if ($urandom_range(9) < 8) s = glyphs[$urandom_range(15)];
            else s = 7'($urandom);
            n = $urandom_range(6, 1);
            for (int k = 0; k < n; k++) begin
                step(a, s, 1'($urandom));
                checks++;
                if (out_valid !== m_valid || out_digits !== m_digits ||
                    out_invalid !== m_invalid || out_overrun !== m_overrun) begin
                    errors++;
                    $display("FAIL random_cycle: got v=%b d=%h i=%b o=%b want v=%b d=%h i=%b o=%b",
                             out_valid, out_digits, out_invalid, out_overrun,
                             m_valid, m_digits, m_invalid, m_overrun);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_glitch();
        test_illegal();
        test_two_hot();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
